// File: rtl/tjmono_direct_tx_if.sv
`default_nettype none
// ============================================================================
// tjmono_direct_tx_if : hit push + token/freeze/read port bundle. Rev 1.0
// ============================================================================
interface tjmono_direct_tx_if #(
  parameter int WORD_WIDTH = 27
);
  logic                  hit_wr;
  logic [WORD_WIDTH-1:0] hit_data;
  logic                  hit_full;
  logic                  freeze;
  logic                  read;
  logic                  token;
  logic                  data;
  logic                  busy;
  logic [7:0]            lost_cnt;
  logic [7:0]            read_err_cnt;

  modport master (
    output hit_wr, hit_data, freeze, read,
    input  hit_full, token, data, busy, lost_cnt, read_err_cnt
  );

  modport slave (
    input  hit_wr, hit_data, freeze, read,
    output hit_full, token, data, busy, lost_cnt, read_err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/tjmono_direct_tx.sv
`default_nettype none
// ============================================================================
// tjmono_direct_tx : TJ-Monopix2 direct readout transmitter emulator. Rev 1.0
// ============================================================================
module tjmono_direct_tx #(
  parameter int WORD_WIDTH = 27,
  parameter int DEPTH      = 16
) (
  input  logic               clk,
  input  logic               rst,
  tjmono_direct_tx_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WORD_WIDTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         frozen_cnt;
  logic                  freeze_d;
  logic                  read_d;
  state_t                state;
  state_t                state_nxt;
  logic [WORD_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_cnt;
  logic                  token_r;
  logic                  data_r;
  logic                  busy_r;
  logic [7:0]            lost_cnt;
  logic [7:0]            read_err_cnt;

  logic full;
  logic read_edge;
  logic push;
  logic drop;
  logic pop;
  logic read_ignored;
  logic token_nxt;

  assign full      = (count == CW'(DEPTH));
  assign read_edge = bus.read & ~read_d;
  // Acceptance looks at the occupancy before any same-cycle pop.
  assign push      = bus.hit_wr & ~full;
  assign drop      = bus.hit_wr & full;

  // On the freeze rising cycle the snapshot equals count, so use count
  // directly to keep TOKEN from glitching low for one cycle.
  assign token_nxt = (bus.freeze && freeze_d) ? (frozen_cnt != '0) : (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    read_ignored = 1'b0;
    case (state)
      IDLE: begin
        if (read_edge) begin
          if (bus.freeze && (frozen_cnt != '0)) begin
            pop       = 1'b1;
            state_nxt = SHIFT;
          end else begin
            read_ignored = 1'b1;
          end
        end
      end
      SHIFT: begin
        read_ignored = read_edge;
        if (bit_cnt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.hit_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze_d   <= 1'b0;
      read_d     <= 1'b0;
      frozen_cnt <= '0;
      token_r    <= 1'b0;
    end else begin
      freeze_d <= bus.freeze;
      read_d   <= bus.read;
      token_r  <= token_nxt;
      if (bus.freeze && !freeze_d) begin
        frozen_cnt <= count;
      end else if (!bus.freeze && freeze_d) begin
        frozen_cnt <= '0;
      end else if (pop) begin
        frozen_cnt <= frozen_cnt - 1'b1;
      end
    end
  end

  // DATA/BUSY are registered: the MSB leaves one cycle after the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      data_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else if (pop) begin
      shreg   <= mem[rd_ptr];
      bit_cnt <= BW'(WORD_WIDTH - 1);
      data_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else if (state == SHIFT) begin
      shreg   <= {shreg[WORD_WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt - 1'b1;
      data_r  <= shreg[WORD_WIDTH-1];
      busy_r  <= 1'b1;
    end else begin
      data_r <= 1'b0;
      busy_r <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost_cnt     <= '0;
      read_err_cnt <= '0;
    end else begin
      if (drop && (lost_cnt != 8'hFF)) begin
        lost_cnt <= lost_cnt + 8'd1;
      end
      if (read_ignored && (read_err_cnt != 8'hFF)) begin
        read_err_cnt <= read_err_cnt + 8'd1;
      end
    end
  end

  assign bus.hit_full     = full;
  assign bus.token        = token_r;
  assign bus.data         = data_r;
  assign bus.busy         = busy_r;
  assign bus.lost_cnt     = lost_cnt;
  assign bus.read_err_cnt = read_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tjmono_direct_tx.sv
`default_nettype none
// ============================================================================
// tb_tjmono_direct_tx : randomized directed bench with a queue-based model.
// ============================================================================
module tb_tjmono_direct_tx;

  localparam int W = 27;
  localparam int D = 16;

  logic clk;
  logic rst;

  tjmono_direct_tx_if #(.WORD_WIDTH(W)) bus ();

  tjmono_direct_tx #(.WORD_WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: hit queue, snapshot size, saturating counters.
  logic [W-1:0] q [$];
  int m_frozen = 0;
  int m_lost   = 0;
  int m_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    return W'($urandom);
  endfunction

  function automatic void model_push(input logic [W-1:0] w);
    if (q.size() < D) q.push_back(w);
    else if (m_lost < 255) m_lost++;
  endfunction

  function automatic void model_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic logic exp_token();
    return bus.freeze ? (m_frozen != 0) : (q.size() != 0);
  endfunction

  task automatic push_word(input logic [W-1:0] w);
    bus.hit_wr   = 1'b1;
    bus.hit_data = w;
    model_push(w);
    tick();
    bus.hit_wr = 1'b0;
    chk("hit_full", 32'(bus.hit_full), 32'(q.size() == D));
  endtask

  task automatic freeze_set(input logic v);
    logic was;
    was        = bus.freeze;
    bus.freeze = v;
    tick();
    if (v && !was) m_frozen = q.size();
    else if (!v) m_frozen = 0;
    tick();
    chk("token_after_freeze", 32'(bus.token), 32'(exp_token()));
  endtask

  // One READ request; optional same-cycle push, extra READ edge at shift
  // cycle err_at, FREEZE fall at shift cycle ffall_at (0 = none).
  task automatic read_word(input logic do_push, input logic [W-1:0] pw,
                           input int err_at, input int ffall_at);
    logic         ok_pop;
    logic [W-1:0] exp_w;
    logic [W-1:0] got;
    logic         anyact;
    exp_w  = '0;
    ok_pop = bus.freeze && (m_frozen > 0);
    bus.read     = 1'b1;
    bus.hit_wr   = do_push;
    bus.hit_data = pw;
    if (do_push) model_push(pw);
    if (ok_pop) begin
      exp_w = q.pop_front();
      m_frozen--;
    end else begin
      model_err();
    end
    tick();
    bus.read   = 1'b0;
    bus.hit_wr = 1'b0;
    got    = '0;
    anyact = 1'b0;
    for (int i = 1; i <= W; i++) begin
      bus.read = (i == err_at);
      if (i == ffall_at) bus.freeze = 1'b0;
      tick();
      if (i == err_at) model_err();
      if (i == ffall_at) m_frozen = 0;
      if (i == 1) begin
        chk("token_n1", 32'(bus.token), 32'(exp_token()));
        chk("busy_n1", 32'(bus.busy), 32'(ok_pop));
      end
      got    = {got[W-2:0], bus.data};
      anyact = anyact | bus.data | bus.busy;
    end
    bus.read = 1'b0;
    tick();
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("data_end", 32'(bus.data), 32'd0);
    if (ok_pop) chk("word", 32'(got), 32'(exp_w));
    else        chk("idle_line", 32'(anyact), 32'd0);
    chk("read_err_cnt", 32'(bus.read_err_cnt), 32'(m_err));
    chk("lost_cnt", 32'(bus.lost_cnt), 32'(m_lost));
    chk("token_end", 32'(bus.token), 32'(exp_token()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst          = 1'b1;
    bus.hit_wr   = 1'b0;
    bus.hit_data = '0;
    bus.freeze   = 1'b0;
    bus.read     = 1'b0;
    repeat (3) tick();
    chk("rst_token", 32'(bus.token), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_full", 32'(bus.hit_full), 32'd0);
    chk("rst_lost", 32'(bus.lost_cnt), 32'd0);
    chk("rst_err", 32'(bus.read_err_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Five sequential words, frozen readout.
    for (int i = 1; i <= 5; i++) push_word(W'(i));
    freeze_set(1'b1);
    for (int i = 0; i < 5; i++) read_word(1'b0, '0, 0, 0);
    freeze_set(1'b0);

    // Snapshot excludes pushes made while frozen.
    push_word(rnd_word());
    push_word(rnd_word());
    freeze_set(1'b1);
    for (int i = 0; i < 3; i++) push_word(rnd_word());
    read_word(1'b0, '0, 0, 0);
    read_word(1'b0, '0, 0, 0);
    read_word(1'b0, '0, 0, 0);
    freeze_set(1'b0);
    freeze_set(1'b1);
    for (int i = 0; i < 3; i++) read_word(1'b0, '0, 0, 0);
    freeze_set(1'b0);

    // Overflow and in-order drain.
    for (int i = 0; i < 20; i++) push_word(rnd_word());
    chk("lost_after_ovf", 32'(bus.lost_cnt), 32'(m_lost));
    freeze_set(1'b1);
    for (int i = 0; i < D; i++) read_word(1'b0, '0, 0, 0);
    freeze_set(1'b0);

    // Wrap-around fill/drain rounds.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(D, 9);
      for (int i = 0; i < n; i++) push_word(rnd_word());
      freeze_set(1'b1);
      for (int i = 0; i < n; i++) read_word(1'b0, '0, 0, 0);
      freeze_set(1'b0);
    end

    // Push and pop in the same cycle, full buffer: push dropped.
    for (int i = 0; i < D; i++) push_word(rnd_word());
    freeze_set(1'b1);
    read_word(1'b1, rnd_word(), 0, 0);
    for (int i = 0; i < D - 1; i++) read_word(1'b0, '0, 0, 0);
    freeze_set(1'b0);

    // Push and pop in the same cycle, half full: both performed.
    for (int i = 0; i < 8; i++) push_word(rnd_word());
    freeze_set(1'b1);
    read_word(1'b1, rnd_word(), 0, 0);
    for (int i = 0; i < 7; i++) read_word(1'b0, '0, 0, 0);
    freeze_set(1'b0);
    freeze_set(1'b1);
    read_word(1'b0, '0, 0, 0);
    freeze_set(1'b0);

    // READ edge during shift, then FREEZE fall mid-word.
    for (int i = 0; i < 4; i++) push_word(rnd_word());
    freeze_set(1'b1);
    read_word(1'b0, '0, 10, 0);
    read_word(1'b0, '0, 0, 12);
    freeze_set(1'b1);
    read_word(1'b0, '0, 0, 0);
    read_word(1'b0, '0, 0, 0);
    freeze_set(1'b0);

    // Reset pulse five cycles into a shift.
    for (int i = 0; i < 3; i++) push_word(rnd_word());
    freeze_set(1'b1);
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_data", 32'(bus.data), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_token", 32'(bus.token), 32'd0);
    chk("rst_mid_count", 32'(dut.count), 32'd0);
    bus.freeze = 1'b0;
    tick();
    rst = 1'b0;
    q.delete();
    m_frozen = 0;
    m_lost   = 0;
    m_err    = 0;
    tick();
    for (int i = 0; i < 3; i++) push_word(rnd_word());
    freeze_set(1'b1);
    for (int i = 0; i < 3; i++) read_word(1'b0, '0, 0, 0);
    freeze_set(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
